// File: rtl/mm_pkg.sv
// Shared types and constants for the guess-entry / feedback pair.
package mm_pkg;

    typedef enum logic [1:0] {
        ENTER,
        COMMIT,
        SETTLE,
        DONE
    } guess_state_t;

    localparam int COLOR_W  = 3;
    localparam int SLOT_CNT = 4;

    localparam logic [1:0] FB_DIRECT   = 2'd2;
    localparam logic [1:0] FB_INDIRECT = 2'd1;
    localparam logic [1:0] FB_NONE     = 2'd0;

    function automatic logic has_dup(
        input logic [COLOR_W-1:0] c0,
        input logic [COLOR_W-1:0] c1,
        input logic [COLOR_W-1:0] c2,
        input logic [COLOR_W-1:0] c3
    );
        return (c0 == c1) || (c0 == c2) || (c0 == c3) ||
               (c1 == c2) || (c1 == c3) || (c2 == c3);
    endfunction

endpackage

// File: rtl/guess_entry_slot_editor.sv
// Four-slot colour edit buffer with per-slot colour wrap and a rotating slot selector.
module slot_editor
    import mm_pkg::*;
#(
    parameter int NUM_COLORS = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               btn_next,
    input  logic               btn_sel,
    output logic [COLOR_W-1:0] edit0,
    output logic [COLOR_W-1:0] edit1,
    output logic [COLOR_W-1:0] edit2,
    output logic [COLOR_W-1:0] edit3,
    output logic [1:0]         sel_slot
);

    localparam logic [COLOR_W-1:0] COLOR_MAX = COLOR_W'(NUM_COLORS - 1);

    logic [COLOR_W-1:0] edit_q [SLOT_CNT];

    // Colour step uses the slot selected before this edge, so next+sel together edit the old slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOT_CNT; i++) begin
                edit_q[i] <= '0;
            end
            sel_slot <= '0;
        end else if (en) begin
            if (btn_next) begin
                edit_q[sel_slot] <= (edit_q[sel_slot] == COLOR_MAX) ? '0
                                                                    : edit_q[sel_slot] + COLOR_W'(1);
            end
            if (btn_sel) begin
                sel_slot <= sel_slot + 2'd1;
            end
        end
    end

    assign edit0 = edit_q[0];
    assign edit1 = edit_q[1];
    assign edit2 = edit_q[2];
    assign edit3 = edit_q[3];

endmodule

// File: rtl/guess_entry.sv
// Guess entry: edits a 4-slot guess, commits it to feedback, counts turns and locks at game end.
// Optional duplicate-colour rejection on submit is enabled by defining GUESS_DUP_REJECT_EN.
module guess_entry
    import mm_pkg::*;
#(
    parameter int MAX_TURNS     = 8,
    parameter int NUM_COLORS    = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_next,
    input  logic               btn_sel,
    input  logic               btn_submit,
    input  logic [1:0]         fb_ssd3,
    input  logic               game_over,
    output logic [COLOR_W-1:0] edit0,
    output logic [COLOR_W-1:0] edit1,
    output logic [COLOR_W-1:0] edit2,
    output logic [COLOR_W-1:0] edit3,
    output logic [1:0]         sel_slot,
    output logic [COLOR_W-1:0] history0,
    output logic [COLOR_W-1:0] history1,
    output logic [COLOR_W-1:0] history2,
    output logic [COLOR_W-1:0] history3,
    output logic               last_turn,
    output logic [3:0]         turn,
    output logic               won,
    output logic               locked
`ifdef GUESS_DUP_REJECT_EN
    ,
    output logic               reject_pulse
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0] TURN_MAX  = 4'(MAX_TURNS);
    localparam logic [3:0] TURN_LAST = 4'(MAX_TURNS - 1);

    guess_state_t     state, state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic             settle_done;
    logic             edit_en;
    logic             dup;
    logic             submit_ok;

    slot_editor #(
        .NUM_COLORS(NUM_COLORS)
    ) u_slot_editor (
        .clk      (clk),
        .rst      (rst),
        .en       (edit_en),
        .btn_next (btn_next),
        .btn_sel  (btn_sel),
        .edit0    (edit0),
        .edit1    (edit1),
        .edit2    (edit2),
        .edit3    (edit3),
        .sel_slot (sel_slot)
    );

`ifdef GUESS_DUP_REJECT_EN
    assign dup = has_dup(edit0, edit1, edit2, edit3);
`else
    assign dup = 1'b0;
`endif

    // A submit pulse swallows any next/sel pulse in the same cycle.
    assign edit_en     = (state == ENTER) && !btn_submit && !game_over;
    assign submit_ok   = (state == ENTER) && btn_submit && !dup;
    assign settle_done = (settle_cnt == SETTLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENTER;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ENTER:  if (submit_ok) state_next = COMMIT;
            COMMIT: state_next = SETTLE;
            SETTLE: begin
                if (settle_done) begin
                    if (fb_ssd3 == FB_DIRECT)  state_next = DONE;
                    else if (turn == TURN_MAX) state_next = DONE;
                    else                       state_next = ENTER;
                end
            end
            DONE:   state_next = DONE;
            default: state_next = ENTER;
        endcase
        if (game_over) state_next = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            history0   <= '0;
            history1   <= '0;
            history2   <= '0;
            history3   <= '0;
            last_turn  <= 1'b0;
            turn       <= '0;
            won        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            settle_cnt <= (state == SETTLE && !settle_done) ? settle_cnt + CNT_W'(1) : '0;
            if (state == COMMIT) begin
                history0  <= edit0;
                history1  <= edit1;
                history2  <= edit2;
                history3  <= edit3;
                last_turn <= (turn == TURN_LAST);
                if (turn != TURN_MAX) turn <= turn + 4'd1;
            end
            if (state == SETTLE && settle_done && fb_ssd3 == FB_DIRECT) won <= 1'b1;
            if (state_next == DONE) locked <= 1'b1;
        end
    end

`ifdef GUESS_DUP_REJECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_pulse <= 1'b0;
        end else begin
            reject_pulse <= (state == ENTER) && btn_submit && dup && !game_over;
        end
    end
`endif

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry (MAX_TURNS=2, NUM_COLORS=6, SETTLE_CYCLES=4).
module tb_guess_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_submit = 1'b0;
    logic [1:0] fb_ssd3 = 2'd0;
    logic       game_over = 1'b0;
    logic [2:0] edit0, edit1, edit2, edit3;
    logic [1:0] sel_slot;
    logic [2:0] history0, history1, history2, history3;
    logic       last_turn;
    logic [3:0] turn;
    logic       won;
    logic       locked;
`ifdef GUESS_DUP_REJECT_EN
    logic       reject_pulse;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    guess_entry #(
        .MAX_TURNS    (2),
        .NUM_COLORS   (6),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_sel    (btn_sel),
        .btn_submit (btn_submit),
        .fb_ssd3    (fb_ssd3),
        .game_over  (game_over),
        .edit0      (edit0),
        .edit1      (edit1),
        .edit2      (edit2),
        .edit3      (edit3),
        .sel_slot   (sel_slot),
        .history0   (history0),
        .history1   (history1),
        .history2   (history2),
        .history3   (history3),
        .last_turn  (last_turn),
        .turn       (turn),
        .won        (won),
        .locked     (locked)
`ifdef GUESS_DUP_REJECT_EN
        ,
        .reject_pulse(reject_pulse)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; consumes exactly one rising edge.
    task automatic press(input logic n, input logic s, input logic b);
        btn_next   = n;
        btn_sel    = s;
        btn_submit = b;
        @(negedge clk);
        btn_next   = 1'b0;
        btn_sel    = 1'b0;
        btn_submit = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_history(input string tag, input logic [11:0] exp);
        check(tag, {history0, history1, history2, history3}, {20'd0, exp});
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_edits", {edit0, edit1, edit2, edit3, sel_slot}, 32'd0);
        check("rst_hist", {history0, history1, history2, history3}, 32'd0);
        check("rst_flags", {last_turn, turn, won, locked}, 32'd0);

        // Colour wrap on slot 0: 7 steps from 0 through 5 back to 1
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
        check("wrap_edit0", edit0, 32'd1);
        check("wrap_sel", sel_slot, 32'd0);
        check("wrap_others", {edit1, edit2, edit3, turn, locked}, 32'd0);

        // Build guess 1,2,3,4
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0);
        check("guess1_edits", {edit0, edit1, edit2, edit3}, {20'd0, 12'o1234});
        check("guess1_sel", sel_slot, 32'd3);

        press(1'b0, 1'b0, 1'b1);
        check("commit_pending_hist", {history0, history1, history2, history3}, 32'd0);
        tick(1);
        check_history("commit1_hist", 12'o1234);
        check("commit1_turn", turn, 32'd1);
        check("commit1_last", last_turn, 32'd0);

        // Buttons during SETTLE are ignored; ENTER resumes after the 4th settle edge
        press(1'b1, 1'b0, 1'b0);
        check("settle_next_ignored", edit3, 32'd4);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("settle_sel_ignored", sel_slot, 32'd3);
        press(1'b0, 1'b1, 1'b0);
        check("enter_resumed_sel", sel_slot, 32'd0);

        // Same-cycle next+sel on slot 1
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("nextsel_edit1", edit1, 32'd3);
        check("nextsel_sel", sel_slot, 32'd2);

        // Same-cycle submit+next: commit only
        press(1'b1, 1'b0, 1'b1);
        check("subnext_edit2", edit2, 32'd3);
        tick(1);
        check_history("commit2_hist", 12'o1334);
        check("commit2_turn", turn, 32'd2);
        check("commit2_last", last_turn, 32'd1);
        tick(3);
        check("settle2_unlocked", locked, 32'd0);
        tick(1);
        check("loss_locked", locked, 32'd1);
        check("loss_won", won, 32'd0);
        press(1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        tick(6);
        check("done_ignore_edit", {edit0, edit1, edit2, edit3, sel_slot}, {18'd0, 12'o1334, 2'd2});
        check("done_ignore_turn", turn, 32'd2);

        // Asynchronous reset out of DONE
        rst = 1'b1;
        #1;
        check("async_rst_done", {locked, turn, last_turn, edit1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Winning guess
        fb_ssd3 = 2'd2;
        press(1'b0, 1'b0, 1'b1);
        tick(1);
        check("win_turn", turn, 32'd1);
        tick(3);
        check("win_pending", {won, locked}, 32'd0);
        tick(1);
        check("win_flags", {won, locked}, 32'b11);
        fb_ssd3 = 2'd0;
        do_reset();
        check("rst_after_win", {won, locked, turn}, 32'd0);

        // Reset in the middle of SETTLE
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        tick(1);
        check("mid_hist0", history0, 32'd1);
        tick(2);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {history0, turn, edit0, last_turn, won, locked}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check("mid_rst_enter", edit0, 32'd1);

        // game_over forces DONE from ENTER
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        check("gameover_locked", locked, 32'd1);
        press(1'b1, 1'b0, 1'b0);
        check("gameover_ignore", edit0, 32'd1);

`ifdef GUESS_DUP_REJECT_EN
        do_reset();
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("dup_reject_hi", reject_pulse, 32'd1);
        tick(1);
        check("dup_reject_lo", reject_pulse, 32'd0);
        tick(6);
        check("dup_turn", turn, 32'd0);
        check("dup_hist", {history0, history1, history2, history3}, 32'd0);
        press(1'b1, 1'b0, 1'b0);
        check("dup_still_enter", edit3, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
